gin_scan_loader: RTL and testbench

GIN_SCAN_LOADER -- requirements
Module: gin_scan_loader

---
 rtl/gin_scan_loader.sv | 170 +++++++++++++++++
 tb/tb_gin_scan_loader.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gin_scan_loader.sv
// gin_scan_loader
// Loads CHAIN_LEN controller IDs into an external ID scan chain and, optionally,
// reads the chain back by rotating it once, comparing every ID against a local
// shadow copy of what was loaded.
//
// Ports
//   clk          sole clock, rising edge
//   rst          asynchronous, active-high reset
//   cfg_start    one-cycle request to begin a load sequence (honoured in IDLE only)
//   verify_en    sampled with an accepted cfg_start; 1 adds a readback pass
//   cfg_valid    cfg_id holds the next ID to load
//   cfg_id       next ID to shift into the chain
//   cfg_ready    loader accepts cfg_id this cycle (LOAD state)
//   set_id       scan-chain shift enable
//   id_scan_in   value presented to the chain head
//   id_scan_out  registered value from the chain tail
//   busy         LOAD or VERIFY in progress
//   done         one-cycle pulse when a sequence completes
//   error        sticky readback-mismatch flag, cleared by the next accepted start
module gin_scan_loader #(
  parameter int ID_LEN    = 5,
  parameter int CHAIN_LEN = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_start,
  input  logic              verify_en,
  input  logic              cfg_valid,
  input  logic [ID_LEN-1:0] cfg_id,
  output logic              cfg_ready,
  output logic              set_id,
  output logic [ID_LEN-1:0] id_scan_in,
  input  logic [ID_LEN-1:0] id_scan_out,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int CNT_W = $clog2(CHAIN_LEN) + 1;
  localparam int IDX_W = $clog2(CHAIN_LEN);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CHAIN_LEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    VERIFY,
    DONE
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  count;
  logic              verify_q;
  logic [ID_LEN-1:0] shadow [CHAIN_LEN];
  logic [IDX_W-1:0]  idx;
  logic              accept;

  // count never exceeds CHAIN_LEN-1 while it is used as an index.
  assign idx    = count[IDX_W-1:0];
  assign accept = (state == LOAD) && cfg_valid;

  // Control FSM. busy, done and cfg_ready are registered alongside the state so
  // they change only on clock edges (or immediately on reset).
  // NOTE: every register here uses non-blocking assignment so all state
  // updates see the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      verify_q  <= 1'b0;
      error     <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      cfg_ready <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cfg_start) begin
            state     <= LOAD;
            verify_q  <= verify_en;
            error     <= 1'b0;
            count     <= '0;
            busy      <= 1'b1;
            cfg_ready <= 1'b1;
          end
        end

        LOAD: begin
          // No timeout: an idle cfg_valid simply holds the chain and count.
          if (cfg_valid) begin
            if (count == LAST) begin
              count     <= '0;
              cfg_ready <= 1'b0;
              if (verify_q) begin
                state <= VERIFY;
              end else begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end else begin
              count <= count + 1'b1;
            end
          end
        end

        VERIFY: begin
          // The first ID loaded sits at the tail, so rotation cycle k presents
          // the k-th accepted ID on id_scan_out.
          if (id_scan_out != shadow[idx]) begin
            error <= 1'b1;
          end
          if (count == LAST) begin
            count <= '0;
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            count <= count + 1'b1;
          end
        end

        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end

        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          done      <= 1'b0;
          cfg_ready <= 1'b0;
        end
      endcase
    end
  end

  // Shadow copy of the loaded IDs, indexed by acceptance order.
  // NOTE: storage arrays carry no reset; their contents are only read after a
  // full load has rewritten every entry, and a reset branch would block RAM
  // inference.
  always_ff @(posedge clk) begin
    if (accept) begin
      shadow[idx] <= cfg_id;
    end
  end

  // Scan-chain drive. set_id follows cfg_valid combinationally in LOAD so an
  // accepted ID shifts into the chain on the same edge it is accepted; VERIFY
  // feeds the tail back to the head to rotate the chain.
  // NOTE: defaults first so every path assigns every output and no latch forms.
  always_comb begin
    set_id     = 1'b0;
    id_scan_in = '0;
    case (state)
      LOAD: begin
        set_id     = cfg_valid;
        id_scan_in = cfg_id;
      end
      VERIFY: begin
        set_id     = 1'b1;
        id_scan_in = id_scan_out;
      end
      default: begin
        set_id     = 1'b0;
        id_scan_in = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_gin_scan_loader.sv
// Testbench for gin_scan_loader: a behavioural model of the external ID scan
// chain, a table of whole-sequence scenarios, and hand-written sequences for
// reset behaviour.
module tb_gin_scan_loader;

  localparam int ID_LEN    = 5;
  localparam int CHAIN_LEN = 14;

  logic              clk = 1'b0;
  logic              rst;
  logic              cfg_start;
  logic              verify_en;
  logic              cfg_valid;
  logic [ID_LEN-1:0] cfg_id;
  logic              cfg_ready;
  logic              set_id;
  logic [ID_LEN-1:0] id_scan_in;
  logic [ID_LEN-1:0] id_scan_out;
  logic              busy;
  logic              done;
  logic              error;

  int passed = 0;
  int total  = 0;

  // Chain model: index 0 is the head, CHAIN_LEN-1 the tail. corrupt_req flips
  // bit 0 of the entry landing at corrupt_pos on that shift edge.
  logic [ID_LEN-1:0] chain [CHAIN_LEN];
  logic              corrupt_req = 1'b0;
  int                corrupt_pos = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (set_id) begin
      chain[0] <= id_scan_in ^ ID_LEN'(corrupt_req && corrupt_pos == 0);
      for (int i = 1; i < CHAIN_LEN; i++) begin
        chain[i] <= chain[i-1] ^ ID_LEN'(corrupt_req && corrupt_pos == i);
      end
    end
  end

  assign id_scan_out = chain[CHAIN_LEN-1];

  gin_scan_loader #(
    .ID_LEN   (ID_LEN),
    .CHAIN_LEN(CHAIN_LEN)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_start  (cfg_start),
    .verify_en  (verify_en),
    .cfg_valid  (cfg_valid),
    .cfg_id     (cfg_id),
    .cfg_ready  (cfg_ready),
    .set_id     (set_id),
    .id_scan_in (id_scan_in),
    .id_scan_out(id_scan_out),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  typedef struct {
    string name;
    logic  ven;        // verify_en with the start
    int    first_id;   // ID sequence: first_id + step*i
    int    step;
    int    gap_after;  // withhold cfg_valid after this many accepts (-1: never)
    int    gap_len;
    int    corrupt_k;  // corrupt the k-th loaded ID in the chain (-1: never)
    logic  noise;      // hold cfg_start high through LOAD and DONE
    int    exp_busy;   // expected busy cycles
    int    exp_setid;  // expected set_id cycles
    logic  exp_error;
    int    exp_err_vk; // first VERIFY cycle showing error (-1: none)
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      passed++;
    end
  endtask

  task automatic run_seq(input vec_t v);
    logic [ID_LEN-1:0] ids [CHAIN_LEN];
    logic [ID_LEN-1:0] e;
    int accepted  = 0;
    int gap_done  = 0;
    int busy_cyc  = 0;
    int setid_cyc = 0;
    int done_cnt  = 0;
    int done_cyc  = -1;
    int last_busy = -1;
    int vk        = 0;
    int first_err = -1;
    int proto_err = 0;
    int gap_err   = 0;
    int chain_err = 0;
    logic in_gap;

    for (int i = 0; i < CHAIN_LEN; i++) ids[i] = ID_LEN'(v.first_id + v.step * i);
    corrupt_pos = (v.corrupt_k >= 0) ? CHAIN_LEN - 1 - v.corrupt_k : 0;

    @(negedge clk);
    cfg_start = 1'b1;
    verify_en = v.ven;
    cfg_valid = 1'b0;
    cfg_id    = '0;
    #1;
    check({v.name, "_idle_busy"}, busy, 0);

    for (int cyc = 0; cyc < 120 && done_cnt == 0; cyc++) begin
      @(negedge clk);
      cfg_start = v.noise;
      verify_en = ~v.ven;
      cfg_valid = 1'b0;
      in_gap    = 1'b0;
      if (accepted < CHAIN_LEN) begin
        if (accepted == v.gap_after && gap_done < v.gap_len) begin
          gap_done++;
          in_gap = 1'b1;
        end else begin
          cfg_valid = 1'b1;
        end
        cfg_id = ids[accepted];
      end else begin
        cfg_id = '0;
      end
      corrupt_req = (v.corrupt_k >= 0) && cfg_valid && (accepted == CHAIN_LEN - 1);
      #1;
      if (cyc == 0) begin
        check({v.name, "_err_clear"}, error, 0);
        check({v.name, "_ready"}, cfg_ready, 1);
      end
      if (busy) begin
        busy_cyc++;
        last_busy = cyc;
      end
      if (set_id) setid_cyc++;
      if (in_gap && set_id) gap_err++;
      if (cfg_ready && cfg_valid) begin
        if (!set_id || id_scan_in !== cfg_id) proto_err++;
        accepted++;
      end else if (busy && !cfg_ready) begin
        if (!set_id || id_scan_in !== id_scan_out) proto_err++;
        if (error && first_err < 0) first_err = vk;
        vk++;
      end else if (!busy) begin
        if (set_id || id_scan_in !== '0) proto_err++;
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
        end
      end
    end

    @(negedge clk);
    cfg_start   = 1'b0;
    cfg_valid   = 1'b0;
    corrupt_req = 1'b0;
    #1;
    check({v.name, "_done_once"}, done, 0);
    check({v.name, "_err_sticky"}, error, v.exp_error);
    @(negedge clk);
    #1;
    check({v.name, "_no_restart"}, busy, 0);

    check({v.name, "_done_cnt"}, done_cnt, 1);
    check({v.name, "_done_time"}, done_cyc, last_busy + 1);
    check({v.name, "_accepted"}, accepted, CHAIN_LEN);
    check({v.name, "_busy_cyc"}, busy_cyc, v.exp_busy);
    check({v.name, "_setid_cyc"}, setid_cyc, v.exp_setid);
    check({v.name, "_proto"}, proto_err, 0);
    check({v.name, "_gap"}, gap_err, 0);
    check({v.name, "_err_vk"}, first_err, v.exp_err_vk);

    for (int i = 0; i < CHAIN_LEN; i++) begin
      e = ids[i] ^ ID_LEN'(i == v.corrupt_k);
      if (chain[CHAIN_LEN-1-i] !== e) chain_err++;
    end
    check({v.name, "_chain_tail"}, chain[CHAIN_LEN-1], ids[0] ^ ID_LEN'(v.corrupt_k == 0));
    check({v.name, "_chain_head"}, chain[0], ids[CHAIN_LEN-1]);
    check({v.name, "_chain_all"}, chain_err, 0);
  endtask

  vec_t vecs [5];

  initial begin
    vecs[0] = '{"load",   1'b0,  0,  1, -1, 0, -1, 1'b0, 14, 14, 1'b0, -1};
    vecs[1] = '{"gap",    1'b0,  0,  1,  5, 3, -1, 1'b0, 17, 14, 1'b0, -1};
    vecs[2] = '{"vpass",  1'b1, 31, -1, -1, 0, -1, 1'b0, 28, 28, 1'b0, -1};
    vecs[3] = '{"vfail",  1'b1, 31, -1, -1, 0,  6, 1'b0, 28, 28, 1'b1,  7};
    vecs[4] = '{"ignore", 1'b0,  0,  1, -1, 0, -1, 1'b1, 14, 14, 1'b0, -1};

    rst       = 1'b0;
    cfg_start = 1'b0;
    verify_en = 1'b0;
    cfg_valid = 1'b0;
    cfg_id    = '0;

    // Reset state, asserted between edges.
    #2 rst = 1'b1;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_ready", cfg_ready, 0);
    check("rst_set_id", set_id, 0);
    check("rst_scan_in", id_scan_in, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int n = 0; n < 5; n++) run_seq(vecs[n]);

    // Reset mid-load: seven accepts, then rst while cfg_valid is still high.
    @(negedge clk);
    cfg_start = 1'b1;
    verify_en = 1'b0;
    @(negedge clk);
    cfg_start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      cfg_valid = 1'b1;
      cfg_id    = ID_LEN'(i);
      @(negedge clk);
    end
    cfg_id = ID_LEN'(7);
    #1;
    check("mid_set_id", set_id, 1);
    check("mid_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", cfg_ready, 0);
    check("mid_rst_set_id", set_id, 0);
    check("mid_rst_scan_in", id_scan_in, 0);
    check("mid_rst_done", done, 0);
    @(negedge clk);
    rst       = 1'b0;
    cfg_valid = 1'b0;
    @(negedge clk);
    cfg_valid = 1'b1;
    #1;
    check("post_rst_idle_set_id", set_id, 0);
    check("post_rst_idle_busy", busy, 0);
    cfg_valid = 1'b0;

    run_seq('{"after_rst", 1'b1, 3, 2, -1, 0, -1, 1'b0, 28, 28, 1'b0, -1});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
